// File: rtl/ra_bist_2r1w_32x32_pkg.sv
// Shared definitions for the 2R1W 32x32 array self-test sequencer:
// geometry, FSM state encodings, compare-pipe payload and the march data pattern.
package ra_bist_2r1w_32x32_pkg;

   localparam int ADR_W = 5;
   localparam int DAT_W = 32;
   localparam int DEPTH = 32;
   localparam int CNT_W = 6;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_W0    = 3'd1;
   localparam logic [2:0] ST_R0    = 3'd2;
   localparam logic [2:0] ST_W1    = 3'd3;
   localparam logic [2:0] ST_R1    = 3'd4;
   localparam logic [2:0] ST_DRAIN = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   // What travels alongside each outstanding read until its data returns
   typedef struct packed {
      logic [0:ADR_W-1] adr;
      logic             phase;
      logic [0:DAT_W-1] exp;
   } cmp_tag_t;

   // March pattern: base (or its inverse) XOR the address replicated across the word
   function automatic logic [0:DAT_W-1] pat_d(input logic [0:DAT_W-1] base,
                                              input logic [0:ADR_W-1] a,
                                              input logic             inv);
      logic [0:DAT_W-1] b;
      b = inv ? ~base : base;
      return b ^ {a, a, a, a, a, a, a[3:4]};
   endfunction

endpackage

// File: rtl/ra_bist_cmp_pipe.sv
// Read-return alignment for one array read port: a delay line of {valid, tag}
// matching the array read latency, with a comparator on the returning data.
module ra_bist_cmp_pipe
   import ra_bist_2r1w_32x32_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vld_i,
   input  logic [0:ADR_W-1] adr_i,
   input  logic             phase_i,
   input  logic [0:DAT_W-1] exp_i,
   input  logic [0:DAT_W-1] dat_i,
   output logic             cmp_vld,
   output logic             miscompare,
   output logic [0:ADR_W-1] adr,
   output logic             phase
);

   logic [RD_LAT-1:0] vld_q;
   cmp_tag_t          tag_q [RD_LAT];

   // Valid chain: cleared by reset so in-flight reads are discarded
   always_ff @(posedge clk) begin
      // NOTE: flops are written with <= so every stage samples its pre-edge neighbour.
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= vld_i;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Tag chain: shifted unconditionally, only meaningful where valid is set
   always_ff @(posedge clk) begin
      // NOTE: the payload is deliberately not reset; the valid bit alone qualifies it.
      tag_q[0] <= {adr_i, phase_i, exp_i};
      for (int i = 1; i < RD_LAT; i++) begin
         tag_q[i] <= tag_q[i-1];
      end
   end

   assign cmp_vld    = vld_q[RD_LAT-1];
   assign adr        = tag_q[RD_LAT-1].adr;
   assign phase      = tag_q[RD_LAT-1].phase;
   assign miscompare = (dat_i != tag_q[RD_LAT-1].exp);

endmodule

// File: rtl/ra_bist_2r1w_32x32.sv
// March-test sequencer (W0, R0, W1, R1) for the registered 2R1W 32x32 array
// wrapper. Drives the wrapper request ports from flops, checks both read ports
// against the expected pattern and keeps pass/fail and first-failure status.
module ra_bist_2r1w_32x32
   import ra_bist_2r1w_32x32_pkg::*;
#(
   parameter logic [0:DAT_W-1] BASE    = 32'hA5C3_0F96,
   parameter int               LATCHRD = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [0:ADR_W-1] fail_adr,
   output logic             fail_port,
   output logic             fail_phase,
   output logic             rd_enb_0,
   output logic [0:ADR_W-1] rd_adr_0,
   input  logic [0:DAT_W-1] rd_dat_0,
   output logic             rd_enb_1,
   output logic [0:ADR_W-1] rd_adr_1,
   input  logic [0:DAT_W-1] rd_dat_1,
   output logic             wr_enb_0,
   output logic [0:ADR_W-1] wr_adr_0,
   output logic [0:DAT_W-1] wr_dat_0
);

   localparam int               RD_LAT     = 1 + LATCHRD;
   localparam logic [0:ADR_W-1] ADR_LAST   = ADR_W'(DEPTH - 1);
   localparam logic [0:ADR_W-1] DRAIN_LAST = ADR_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] ERR_MAX    = '1;

   logic [2:0]       state_q, state_d;
   logic [0:ADR_W-1] adr_q, adr_d;
   logic             clr;
   logic             adr_last;

   logic             busy_q, busy_d, done_q, done_d;
   logic             wr_enb_q, wr_enb_d, rd_enb_q, rd_enb_d, inv_d, rd_phase_q;
   logic [0:ADR_W-1] wr_adr_q, wr_adr_d, rd_adr_0_q, rd_adr_0_d, rd_adr_1_q, rd_adr_1_d;
   logic [0:DAT_W-1] wr_dat_q, wr_dat_d;

   logic             fail_q, fail_port_q, fail_phase_q;
   logic [CNT_W-1:0] err_cnt_q, err_inc;
   logic [CNT_W:0]   err_sum;
   logic [0:ADR_W-1] fail_adr_q;

   logic             cmp_vld_0, cmp_vld_1, mis_raw_0, mis_raw_1, mis_0, mis_1;
   logic [0:ADR_W-1] cmp_adr_0, cmp_adr_1;
   logic             cmp_phase_0, cmp_phase_1;
   logic [0:DAT_W-1] exp_0, exp_1;

   assign adr_last = (adr_q == ADR_LAST);

   // Phase sequencing; the address counter wraps to 0 at every phase change
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      adr_d   = adr_q + ADR_W'(1);
      clr     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            adr_d = '0;
            if (start) begin
               state_d = ST_W0;
               clr     = 1'b1;
            end
         end
         ST_W0: if (adr_last) state_d = ST_R0;
         ST_R0: if (adr_last) state_d = ST_W1;
         ST_W1: if (adr_last) state_d = ST_R1;
         ST_R1: if (adr_last) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (adr_q == DRAIN_LAST) begin
               state_d = ST_DONE;
               adr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            adr_d   = '0;
         end
      endcase
   end

   // Request/handshake values for the coming cycle, registered below
   always_comb begin
      wr_enb_d   = (state_d == ST_W0) || (state_d == ST_W1);
      rd_enb_d   = (state_d == ST_R0) || (state_d == ST_R1);
      inv_d      = (state_d == ST_W1) || (state_d == ST_R1);
      busy_d     = state_d inside {ST_W0, ST_R0, ST_W1, ST_R1, ST_DRAIN};
      done_d     = (state_d == ST_DONE);
      wr_adr_d   = '0;
      wr_dat_d   = '0;
      rd_adr_0_d = '0;
      rd_adr_1_d = '0;
      if (wr_enb_d) begin
         // W1 walks the array top-down using the inverted counter
         wr_adr_d = (state_d == ST_W1) ? ~adr_d : adr_d;
         wr_dat_d = pat_d(BASE, wr_adr_d, inv_d);
      end
      if (rd_enb_d) begin
         rd_adr_0_d = adr_d;
         rd_adr_1_d = ~adr_d;
      end
   end

   // FSM, counter and all request outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         adr_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_enb_q   <= 1'b0;
         wr_adr_q   <= '0;
         wr_dat_q   <= '0;
         rd_enb_q   <= 1'b0;
         rd_adr_0_q <= '0;
         rd_adr_1_q <= '0;
         rd_phase_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_enb_q   <= wr_enb_d;
         wr_adr_q   <= wr_adr_d;
         wr_dat_q   <= wr_dat_d;
         rd_enb_q   <= rd_enb_d;
         rd_adr_0_q <= rd_adr_0_d;
         rd_adr_1_q <= rd_adr_1_d;
         rd_phase_q <= rd_enb_d & inv_d;
      end
   end

   assign exp_0 = pat_d(BASE, rd_adr_0_q, rd_phase_q);
   assign exp_1 = pat_d(BASE, rd_adr_1_q, rd_phase_q);

   ra_bist_cmp_pipe #(.RD_LAT(RD_LAT)) u_pipe_0 (
      .clk        (clk),
      .reset      (reset),
      .vld_i      (rd_enb_q),
      .adr_i      (rd_adr_0_q),
      .phase_i    (rd_phase_q),
      .exp_i      (exp_0),
      .dat_i      (rd_dat_0),
      .cmp_vld    (cmp_vld_0),
      .miscompare (mis_raw_0),
      .adr        (cmp_adr_0),
      .phase      (cmp_phase_0)
   );

   ra_bist_cmp_pipe #(.RD_LAT(RD_LAT)) u_pipe_1 (
      .clk        (clk),
      .reset      (reset),
      .vld_i      (rd_enb_q),
      .adr_i      (rd_adr_1_q),
      .phase_i    (rd_phase_q),
      .exp_i      (exp_1),
      .dat_i      (rd_dat_1),
      .cmp_vld    (cmp_vld_1),
      .miscompare (mis_raw_1),
      .adr        (cmp_adr_1),
      .phase      (cmp_phase_1)
   );

   assign mis_0   = cmp_vld_0 & mis_raw_0;
   assign mis_1   = cmp_vld_1 & mis_raw_1;
   assign err_sum = {1'b0, err_cnt_q} + {{CNT_W{1'b0}}, mis_0} + {{CNT_W{1'b0}}, mis_1};
   assign err_inc = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[CNT_W-1:0];

   // Sticky fail, saturating error count and first-failure capture (port 0 wins ties)
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         fail_q       <= 1'b0;
         err_cnt_q    <= '0;
         fail_adr_q   <= '0;
         fail_port_q  <= 1'b0;
         fail_phase_q <= 1'b0;
      end else if (mis_0 || mis_1) begin
         fail_q    <= 1'b1;
         err_cnt_q <= err_inc;
         if (!fail_q) begin
            fail_port_q  <= !mis_0;
            fail_adr_q   <= mis_0 ? cmp_adr_0 : cmp_adr_1;
            fail_phase_q <= mis_0 ? cmp_phase_0 : cmp_phase_1;
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign fail       = fail_q;
   assign err_cnt    = err_cnt_q;
   assign fail_adr   = fail_adr_q;
   assign fail_port  = fail_port_q;
   assign fail_phase = fail_phase_q;
   assign rd_enb_0   = rd_enb_q;
   assign rd_enb_1   = rd_enb_q;
   assign rd_adr_0   = rd_adr_0_q;
   assign rd_adr_1   = rd_adr_1_q;
   assign wr_enb_0   = wr_enb_q;
   assign wr_adr_0   = wr_adr_q;
   assign wr_dat_0   = wr_dat_q;

endmodule

// File: tb/tb_ra_bist_2r1w_32x32.sv
// Bench for the march sequencer: two sequencers (LATCHRD=1 and LATCHRD=0), each
// attached to a behavioural array with programmable read-data corruption.
// Expected status comes from walking the march order over the corruption table.
module tb_ra_bist_2r1w_32x32;

   localparam logic [31:0] BASE = 32'hA5C3_0F96;
   localparam logic [31:0] W5   = 32'hA5C3_0F96 ^ {{6{5'd5}}, 2'b01};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, extra_b;
   int   total = 0;
   int   bad   = 0;

   // Corruption XOR mask per [read phase][port][address]; 0 means clean data
   logic [31:0] fmask [2][2][32];

   logic       busy_a, done_a, fail_a, fport_a, fph_a, rde0_a, rde1_a, wre_a;
   logic [5:0] err_a;
   logic [0:4] fadr_a, rda0_a, rda1_a, wra_a;
   logic [0:31] rdd0_a, rdd1_a, wrd_a;
   logic       busy_b, done_b, fail_b, fport_b, fph_b, rde0_b, rde1_b, wre_b;
   logic [5:0] err_b;
   logic [0:4] fadr_b, rda0_b, rda1_b, wra_b;
   logic [0:31] rdd0_b, rdd1_b, wrd_b;

   ra_bist_2r1w_32x32 #(.BASE(BASE), .LATCHRD(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
      .fail(fail_a), .err_cnt(err_a), .fail_adr(fadr_a), .fail_port(fport_a),
      .fail_phase(fph_a), .rd_enb_0(rde0_a), .rd_adr_0(rda0_a), .rd_dat_0(rdd0_a),
      .rd_enb_1(rde1_a), .rd_adr_1(rda1_a), .rd_dat_1(rdd1_a),
      .wr_enb_0(wre_a), .wr_adr_0(wra_a), .wr_dat_0(wrd_a));

   ra_bist_2r1w_32x32 #(.BASE(BASE), .LATCHRD(0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
      .fail(fail_b), .err_cnt(err_b), .fail_adr(fadr_b), .fail_port(fport_b),
      .fail_phase(fph_b), .rd_enb_0(rde0_b), .rd_adr_0(rda0_b), .rd_dat_0(rdd0_b),
      .rd_enb_1(rde1_b), .rd_adr_1(rda1_b), .rd_dat_1(rdd1_b),
      .wr_enb_0(wre_b), .wr_adr_0(wra_b), .wr_dat_0(wrd_b));

   // Behavioural arrays: A returns data two cycles after the request, B one
   logic [31:0] mem_a [32];
   logic [31:0] mem_b [32];
   logic [31:0] s0_0a, s0_1a, s1_0a, s1_1a, s0_0b, s0_1b, s1_0b, s1_1b;
   int          rcnt_a, rcnt_b;

   always @(posedge clk) begin
      if (wre_a) mem_a[wra_a] <= wrd_a;
      if (rde0_a) s0_0a <= mem_a[rda0_a] ^ fmask[rcnt_a >= 32][0][rda0_a];
      if (rde1_a) s0_1a <= mem_a[rda1_a] ^ fmask[rcnt_a >= 32][1][rda1_a];
      s1_0a <= s0_0a;
      s1_1a <= s0_1a;
      if (!busy_a) rcnt_a <= 0;
      else if (rde0_a) rcnt_a <= rcnt_a + 1;
   end

   always @(posedge clk) begin
      if (wre_b) mem_b[wra_b] <= wrd_b;
      if (rde0_b) s0_0b <= mem_b[rda0_b] ^ fmask[rcnt_b >= 32][0][rda0_b];
      if (rde1_b) s0_1b <= mem_b[rda1_b] ^ fmask[rcnt_b >= 32][1][rda1_b];
      s1_0b <= s0_0b;
      s1_1b <= s0_1b;
      if (!busy_b) rcnt_b <= 0;
      else if (rde0_b) rcnt_b <= rcnt_b + 1;
   end

   assign rdd0_a = s1_0a;
   assign rdd1_a = s1_1a;
   assign rdd0_b = extra_b ? s1_0b : s0_0b;
   assign rdd1_b = extra_b ? s1_1b : s0_1b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tb_pat(input int a, input bit inv);
      logic [4:0] av;
      av = a[4:0];
      return (inv ? ~BASE : BASE) ^ {{6{av}}, av[1:0]};
   endfunction

   // Request-stream monitor on A: write k and read k of a run are fully determined
   int wr_k, rd_k;
   always @(negedge clk) begin
      int e_adr;
      if (busy_a !== 1'b1) begin
         wr_k = 0;
         rd_k = 0;
      end else begin
         check("wr_rd_overlap", wre_a & (rde0_a | rde1_a), 0);
         check("rd_enb_pair", rde1_a, rde0_a);
         if (wre_a) begin
            e_adr = (wr_k < 32) ? wr_k : 63 - wr_k;
            check("wr_adr", wra_a, e_adr);
            check("wr_dat", wrd_a, tb_pat(e_adr, wr_k >= 32));
            if (wr_k == 5) check("wr_dat_adr5", wrd_a, W5);
            wr_k++;
         end
         if (rde0_a) begin
            check("rd_adr_0", rda0_a, rd_k % 32);
            check("rd_adr_1", rda1_a, 31 - (rd_k % 32));
            rd_k++;
         end
      end
   end

   task automatic clear_masks();
      for (int ph = 0; ph < 2; ph++)
         for (int p = 0; p < 2; p++)
            for (int a = 0; a < 32; a++) fmask[ph][p][a] = '0;
   endtask

   // Reference: walk reads in issue order (R0 then R1, port 0 before port 1)
   task automatic predict(output int e_err, output bit e_fail, output int e_adr,
                          output bit e_port, output bit e_ph);
      e_err = 0; e_fail = 0; e_adr = 0; e_port = 0; e_ph = 0;
      for (int ph = 0; ph < 2; ph++)
         for (int i = 0; i < 32; i++)
            for (int p = 0; p < 2; p++) begin
               int a;
               a = (p == 0) ? i : 31 - i;
               if (fmask[ph][p][a] != '0) begin
                  if (!e_fail) begin
                     e_fail = 1; e_adr = a; e_port = p[0]; e_ph = ph[0];
                  end
                  if (e_err < 63) e_err++;
               end
            end
   endtask

   task automatic run(input string tag, input int poke, input bit chk_b);
      int  e_err, e_adr, n, ca, cb;
      bit  e_fail, e_port, e_ph;
      predict(e_err, e_fail, e_adr, e_port, e_ph);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0; ca = 0; cb = 0;
      while (!(done_a && done_b) && n < 400) begin
         if (busy_a) ca++;
         if (busy_b) cb++;
         n++;
         start = (n == poke);
         @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("%s/in_time", tag), n < 400, 1);
      check($sformatf("%s/busy_cyc_a", tag), ca, 130);
      check($sformatf("%s/busy_cyc_b", tag), cb, 129);
      check($sformatf("%s/status_a", tag), {busy_a, done_a, fail_a}, {2'b01, e_fail});
      check($sformatf("%s/err_a", tag), err_a, e_err);
      check($sformatf("%s/first_a", tag), {fadr_a, fport_a, fph_a}, {e_adr[4:0], e_port, e_ph});
      if (chk_b) begin
         check($sformatf("%s/status_b", tag), {busy_b, done_b, fail_b}, {2'b01, e_fail});
         check($sformatf("%s/err_b", tag), err_b, e_err);
         check($sformatf("%s/first_b", tag), {fadr_b, fport_b, fph_b}, {e_adr[4:0], e_port, e_ph});
      end
      repeat (3) @(negedge clk);
      check($sformatf("%s/done_held", tag), {done_a, done_b, busy_a, busy_b}, 4'b1100);
   endtask

   initial begin
      int n;
      logic [31:0] m;
      reset = 1'b1; start = 1'b0; extra_b = 1'b0;
      clear_masks();
      repeat (3) @(negedge clk);
      check("reset_a", {busy_a, done_a, fail_a, err_a, fadr_a, fport_a, fph_a,
                        rde0_a, rde1_a, wre_a, rda0_a, rda1_a, wra_a, wrd_a}, 0);
      check("reset_b", {busy_b, done_b, fail_b, err_b, fadr_b, fport_b, fph_b,
                        rde0_b, rde1_b, wre_b, rda0_b, rda1_b, wra_b, wrd_b}, 0);
      reset = 1'b0;
      @(negedge clk);

      run("clean", -1, 1);

      m = '0; m[7] = 1'b1;
      fmask[0][0][3] = m;
      run("p0_r0_adr3", -1, 1);

      clear_masks();
      for (int a = 0; a < 32; a++) fmask[1][1][a] = tb_pat(a, 1);
      run("p1_r1_zero", -1, 1);

      for (int ph = 0; ph < 2; ph++)
         for (int p = 0; p < 2; p++)
            for (int a = 0; a < 32; a++) fmask[ph][p][a] = '1;
      run("all_inverted", -1, 1);

      clear_masks();
      extra_b = 1'b1;
      run("b_late_data", -1, 0);
      check("b_late_data/fail_b", fail_b, 1);
      extra_b = 1'b0;

      // Mid-run reset with corrupted R0 data still in flight
      for (int a = 0; a < 32; a++) begin
         fmask[0][0][a] = '1;
         fmask[0][1][a] = '1;
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!(rde0_a && rda0_a == 5'd10) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid/found_r0_adr10", n < 300, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid/idle_a", {rde0_a, rde1_a, wre_a, busy_a, done_a}, 0);
      check("rst_mid/idle_b", {rde0_b, rde1_b, wre_b, busy_b, done_b}, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_mid/flushed", {fail_a, err_a, fail_b, err_b}, 0);
      end
      clear_masks();
      run("after_rst_poke_w1", 70, 1);

      // Randomised corruption patterns of varying density
      for (int r = 0; r < 4; r++) begin
         int dens;
         dens = $urandom_range(0, 9);
         for (int ph = 0; ph < 2; ph++)
            for (int p = 0; p < 2; p++)
               for (int a = 0; a < 32; a++)
                  fmask[ph][p][a] = ($urandom_range(0, 99) < dens * dens) ? ($urandom | 32'h1) : '0;
         run($sformatf("random%0d", r), -1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
